btn_event_classifier: RTL and testbench

BTN_EVENT_CLASSIFIER -- requirements
Module: btn_event_classifier

---
 rtl/btn_event_classifier.sv | 144 ++++++++++++++
 tb/tb_btn_event_classifier.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_classifier.sv
// btn_event_classifier
// Classifies presses of an already-debounced button into single, double or
// long press events, each reported as a one-cycle pulse.
//
// Parameters:
//   CLK_PERIOD_NS - clock period in ns, used to turn the times below into cycles
//   LONG_NS       - minimum hold time for a long press
//   GAP_NS        - maximum release gap between the two halves of a double press
//
// Ports:
//   clk_i         - clock, all logic on the rising edge
//   rst_ni        - asynchronous active-low reset
//   debounced_i   - debounced button level, synchronous to clk_i, 1 = pressed
//   single_o      - one-cycle pulse, single short press classified
//   double_o      - one-cycle pulse, double press classified
//   long_o        - one-cycle pulse, long press classified
//   busy_o        - high whenever the classifier is not idle
//   event_count_o - number of classified events, modulo 256
module btn_event_classifier #(
  parameter int CLK_PERIOD_NS = 10,
  parameter int LONG_NS       = 500,
  parameter int GAP_NS        = 200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       debounced_i,
  output logic       single_o,
  output logic       double_o,
  output logic       long_o,
  output logic       busy_o,
  output logic [7:0] event_count_o
);

  localparam int LONG_CYC = LONG_NS / CLK_PERIOD_NS;
  localparam int GAP_CYC  = GAP_NS / CLK_PERIOD_NS;
  localparam int MAX_CYC  = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int CNT_W    = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  // The sample that moves the FSM into PRESS1 (or WAIT_GAP) is already the
  // first sample of that phase, with cnt cleared to 0. The Nth consecutive
  // sample is therefore seen with cnt == N-2, which is why the terminal
  // values are LONG_CYC-2 and GAP_CYC-2.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 2);

  if ((LONG_CYC < 2) || (GAP_CYC < 2)) begin : g_param_check
    $error("btn_event_classifier: LONG_CYC and GAP_CYC must both be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS1,
    WAIT_GAP,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             single_d, double_d, long_d;
  logic             single_q, double_q, long_q, busy_q;
  logic [7:0]       count_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    single_d = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (debounced_i) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (debounced_i) begin
          if (cnt_q == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = WAIT_GAP;
          cnt_d   = '0;
        end
      end
      // A second press wins over the gap timeout on the same edge.
      WAIT_GAP: begin
        if (debounced_i) begin
          double_d = 1'b1;
          state_d  = HOLD;
        end else if (cnt_q == GAP_LAST) begin
          single_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // HOLD only waits for release, so a long press or the second half of a
      // double press can never be reclassified.
      HOLD: begin
        if (!debounced_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // busy is registered from the next state so that it tracks the state
  // register exactly while still coming straight out of a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      single_q <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      double_q <= double_d;
      long_q   <= long_d;
      busy_q   <= (state_d != IDLE);
      if (single_d || double_d || long_d) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign single_o      = single_q;
  assign double_o      = double_q;
  assign long_o        = long_q;
  assign busy_o        = busy_q;
  assign event_count_o = count_q;

endmodule

// File: tb/tb_btn_event_classifier.sv
// tb_btn_event_classifier
// Directed self-checking bench for btn_event_classifier with default
// parameters (LONG_CYC = 50, GAP_CYC = 20). Each step drives one level,
// waits for the rising edge and samples the registered outputs 1 ns later,
// so a pulse seen after step N belongs to the sample taken at step N.
module tb_btn_event_classifier;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       debounced_i;
  logic       single_o;
  logic       double_o;
  logic       long_o;
  logic       busy_o;
  logic [7:0] event_count_o;

  int checks = 0;
  int fails  = 0;

  int         seg;
  int         n_single;
  int         n_double;
  int         n_long;
  int         single_first;
  int         single_last;
  int         double_at;
  int         long_at;
  int         nz_cycles;
  int         excl_bad = 0;
  logic [7:0] ec_at_pulse;

  btn_event_classifier dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .debounced_i  (debounced_i),
    .single_o     (single_o),
    .double_o     (double_o),
    .long_o       (long_o),
    .busy_o       (busy_o),
    .event_count_o(event_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_stats();
    seg          = 0;
    n_single     = 0;
    n_double     = 0;
    n_long       = 0;
    single_first = 0;
    single_last  = 0;
    double_at    = 0;
    long_at      = 0;
    nz_cycles    = 0;
    ec_at_pulse  = 8'd0;
  endtask

  // Drives the given level for n clock edges and logs every pulse position.
  task automatic apply_stimulus(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      debounced_i = level;
      @(posedge clk_i);
      #1;
      seg++;
      if (single_o === 1'b1) begin
        n_single++;
        if (single_first == 0) single_first = seg;
        single_last = seg;
        ec_at_pulse = event_count_o;
      end
      if (double_o === 1'b1) begin
        n_double++;
        double_at   = seg;
        ec_at_pulse = event_count_o;
      end
      if (long_o === 1'b1) begin
        n_long++;
        long_at     = seg;
        ec_at_pulse = event_count_o;
      end
      if ((int'(single_o) + int'(double_o) + int'(long_o)) > 1) excl_bad++;
      if (single_o || double_o || long_o || busy_o || (event_count_o != 8'd0)) nz_cycles++;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Resets the DUT for one edge with the button released, then clears the log.
  task automatic restart();
    rst_ni      = 1'b0;
    debounced_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    clear_stats();
  endtask

  initial begin
    $display("[TB] btn_event_classifier directed test");
    clear_stats();

    // Reset acts without any clock edge.
    rst_ni      = 1'b0;
    debounced_i = 1'b0;
    #1;
    check_output("async_reset_pulses", {single_o, double_o, long_o, busy_o}, 32'd0);
    check_output("async_reset_count", event_count_o, 32'd0);

    // Held in reset while the button toggles: everything stays quiet.
    for (int i = 0; i < 8; i++) apply_stimulus(logic'(i % 2 == 0), 2);
    check_output("reset_quiet_cycles", nz_cycles, 32'd0);
    check_output("reset_no_pulses", n_single + n_double + n_long, 32'd0);
    debounced_i = 1'b0;
    rst_ni      = 1'b1;
    clear_stats();

    // Single press: high 10, low 30.
    apply_stimulus(1'b1, 10);
    check_output("single_busy_during_press", busy_o, 32'd1);
    apply_stimulus(1'b0, 30);
    check_output("single_count", n_single, 32'd1);
    check_output("single_position", single_last, 32'd30);
    check_output("single_no_other", n_double + n_long, 32'd0);
    check_output("single_ec_with_pulse", ec_at_pulse, 32'd1);
    check_output("single_event_count", event_count_o, 32'd1);
    check_output("single_busy_after", busy_o, 32'd0);

    // Double press: high 5, low 5, high 5, low 30.
    restart();
    apply_stimulus(1'b1, 5);
    apply_stimulus(1'b0, 5);
    apply_stimulus(1'b1, 5);
    apply_stimulus(1'b0, 30);
    check_output("double_count", n_double, 32'd1);
    check_output("double_position", double_at, 32'd11);
    check_output("double_no_other", n_single + n_long, 32'd0);
    check_output("double_event_count", event_count_o, 32'd1);
    check_output("double_busy_after", busy_o, 32'd0);

    // Long press: high 60, then released.
    restart();
    apply_stimulus(1'b1, 60);
    check_output("long_busy_in_hold", busy_o, 32'd1);
    apply_stimulus(1'b0, 30);
    check_output("long_count", n_long, 32'd1);
    check_output("long_position", long_at, 32'd50);
    check_output("long_no_other", n_single + n_double, 32'd0);
    check_output("long_ec_with_pulse", ec_at_pulse, 32'd1);
    check_output("long_event_count", event_count_o, 32'd1);
    check_output("long_busy_after", busy_o, 32'd0);

    // Gap boundary, 19 low samples: still a double press.
    restart();
    apply_stimulus(1'b1, 5);
    apply_stimulus(1'b0, 19);
    apply_stimulus(1'b1, 5);
    apply_stimulus(1'b0, 30);
    check_output("gap19_double_count", n_double, 32'd1);
    check_output("gap19_double_position", double_at, 32'd25);
    check_output("gap19_no_single", n_single, 32'd0);

    // Gap boundary, 20 low samples: single, and the next press starts over.
    restart();
    apply_stimulus(1'b1, 5);
    apply_stimulus(1'b0, 20);
    apply_stimulus(1'b1, 5);
    apply_stimulus(1'b0, 30);
    check_output("gap20_single_count", n_single, 32'd2);
    check_output("gap20_first_single", single_first, 32'd25);
    check_output("gap20_second_single", single_last, 32'd50);
    check_output("gap20_no_double", n_double, 32'd0);
    check_output("gap20_event_count", event_count_o, 32'd2);

    // Second press held far beyond the long time: double only.
    restart();
    apply_stimulus(1'b1, 5);
    apply_stimulus(1'b0, 5);
    apply_stimulus(1'b1, 70);
    apply_stimulus(1'b0, 5);
    check_output("dbl_held_double_position", double_at, 32'd11);
    check_output("dbl_held_no_long", n_long, 32'd0);
    check_output("dbl_held_no_single", n_single, 32'd0);
    check_output("dbl_held_event_count", event_count_o, 32'd1);

    // Reset pulse in the middle of the release gap aborts the single press.
    restart();
    apply_stimulus(1'b1, 5);
    apply_stimulus(1'b0, 10);
    check_output("midgap_busy_before", busy_o, 32'd1);
    rst_ni = 1'b0;
    #1;
    check_output("midgap_async_clear", {single_o, double_o, long_o, busy_o}, 32'd0);
    apply_stimulus(1'b0, 2);
    rst_ni = 1'b1;
    apply_stimulus(1'b0, 30);
    check_output("midgap_no_single", n_single, 32'd0);
    check_output("midgap_event_count", event_count_o, 32'd0);
    check_output("midgap_busy_after", busy_o, 32'd0);

    // Button already pressed when reset releases: first edge is a new press.
    rst_ni      = 1'b0;
    debounced_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_stats();
    rst_ni = 1'b1;
    apply_stimulus(1'b1, 60);
    apply_stimulus(1'b0, 5);
    check_output("press_at_release_long", n_long, 32'd1);
    check_output("press_at_release_position", long_at, 32'd50);
    check_output("press_at_release_count", event_count_o, 32'd1);

    // 256 single presses wrap the event counter back to 0.
    restart();
    for (int k = 0; k < 255; k++) begin
      apply_stimulus(1'b1, 1);
      apply_stimulus(1'b0, 20);
    end
    check_output("wrap_count_255", event_count_o, 32'd255);
    apply_stimulus(1'b1, 1);
    apply_stimulus(1'b0, 20);
    check_output("wrap_count_0", event_count_o, 32'd0);
    check_output("wrap_single_total", n_single, 32'd256);
    check_output("wrap_last_position", single_last, 32'd5376);

    check_output("pulses_exclusive", excl_bad, 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
